// File: rtl/electron_nest.sv
`default_nettype none
// ============================================================================
//  Module   : electron_nest
//  Brief    : Compute-fabric stub. Boots from a token stream on the load port,
//             copies N words from external memory into an internal BRAM, then
//             writes them back to a second external range via the store port.
//  Options  : EXTEND_MEM_EN - index-compressed memory (load write index taken
//             from the returned token index, store token carries address bits)
//  Revision : 1.0 - initial release
// ============================================================================
module electron_nest #(
    parameter int WIDTH_DATA   = 32,
    parameter int WIDTH_EXADDR = 32,
    parameter int WIDTH_INDEX  = 10,
    parameter int BRAM_DEPTH   = 256
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              I_Boot,
    output logic                              O_Ld_Req,
    output logic [WIDTH_EXADDR-1:0]           O_Ld_Addr,
    input  logic [WIDTH_INDEX+WIDTH_DATA+3:0] I_Ld_FTk,
    output logic [3:0]                        O_Ld_BTk,
    output logic                              O_St_Req,
    output logic [WIDTH_EXADDR-1:0]           O_St_Addr,
    output logic [WIDTH_INDEX+WIDTH_DATA+3:0] O_St_FTk,
    input  logic [3:0]                        I_St_BTk
);

    // BRAM addressing relies on truncation, so BRAM_DEPTH is a power of two.
    localparam int c_BRAM_AW = $clog2(BRAM_DEPTH);
    localparam int c_LEN_W   = $clog2(BRAM_DEPTH + 1);

    // Forward token layout {v, a, c, r, i, d}, v in the MSB.
    localparam int c_FTK_V = WIDTH_INDEX + WIDTH_DATA + 3;
    localparam int c_FTK_A = WIDTH_INDEX + WIDTH_DATA + 2;
    localparam int c_FTK_C = WIDTH_INDEX + WIDTH_DATA + 1;
    localparam int c_FTK_R = WIDTH_INDEX + WIDTH_DATA;
    // Backward token layout {n, t, v, c}, n in the MSB.
    localparam int c_BTK_N = 3;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_BOOT  = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_STORE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;

    // Boot framing and descriptor
    logic                    r_started;
    logic [2:0]              r_word_cnt;
    logic [WIDTH_EXADDR-1:0] r_lb;
    logic [WIDTH_EXADDR-1:0] r_sb;
    logic [c_LEN_W-1:0]      r_len;
    logic [c_BRAM_AW-1:0]    r_bb;
    logic                    r_rev;

    // Load / store progress
    logic [c_LEN_W-1:0]      r_issue_cnt;
    logic [c_LEN_W-1:0]      r_resp_cnt;
    logic [c_LEN_W-1:0]      r_rd_cnt;
    logic                    r_ld_req;
    logic [WIDTH_EXADDR-1:0] r_ld_addr;
    logic                    r_st_req;
    logic [WIDTH_EXADDR-1:0] r_st_addr;

    logic [WIDTH_DATA-1:0]   r_mem [BRAM_DEPTH];
    logic [WIDTH_DATA-1:0]   r_bram_q;

    logic                    w_tok_v;
    logic                    w_tok_a;
    logic [WIDTH_INDEX-1:0]  w_tok_i;
    logic [WIDTH_DATA-1:0]   w_tok_d;
    logic                    w_tok_take;
    logic                    w_boot_exit;
    logic [c_LEN_W-1:0]      w_len_clamped;
    logic                    w_ld_resp;
    logic                    w_ld_last;
    logic [c_BRAM_AW-1:0]    w_wr_idx;
    logic                    w_st_adv;
    logic                    w_rd_en;
    logic                    w_st_last;
    logic [c_LEN_W-1:0]      w_rd_off;
    logic [c_BRAM_AW-1:0]    w_rd_idx;
    logic [WIDTH_INDEX-1:0]  w_st_index;
    logic                    w_unused;

    assign w_tok_v = I_Ld_FTk[c_FTK_V];
    assign w_tok_a = I_Ld_FTk[c_FTK_A];
    assign w_tok_i = I_Ld_FTk[WIDTH_INDEX+WIDTH_DATA-1:WIDTH_DATA];
    assign w_tok_d = I_Ld_FTk[WIDTH_DATA-1:0];

    // Once an a=1 word has been seen, every valid word advances the frame;
    // a fresh a=1 word always restarts it at word 0.
    assign w_tok_take  = (r_state == c_ST_BOOT) && w_tok_v && (w_tok_a || r_started);
    assign w_boot_exit = w_tok_take && !w_tok_a && (r_word_cnt == 3'd7);

    assign w_len_clamped = (w_tok_d > WIDTH_DATA'(BRAM_DEPTH)) ? c_LEN_W'(BRAM_DEPTH)
                                                               : c_LEN_W'(w_tok_d);

    assign w_ld_resp = (r_state == c_ST_LOAD) && w_tok_v && (r_resp_cnt < r_len);
    assign w_ld_last = w_ld_resp && (r_resp_cnt == (r_len - c_LEN_W'(1)));

`ifdef EXTEND_MEM_EN
    assign w_wr_idx   = c_BRAM_AW'(w_tok_i) - c_BRAM_AW'(r_lb) + r_bb;
    assign w_st_index = WIDTH_INDEX'(r_st_addr);
`else
    assign w_wr_idx   = r_bb + c_BRAM_AW'(r_resp_cnt);
    assign w_st_index = '0;
`endif

    // The output register doubles as the BRAM read register: it only moves
    // when the current word is accepted or the slot is empty.
    assign w_st_adv  = (r_state == c_ST_STORE) && (!r_st_req || !I_St_BTk[c_BTK_N]);
    assign w_rd_en   = w_st_adv && (r_rd_cnt < r_len);
    assign w_st_last = w_st_adv && r_st_req && (r_rd_cnt == r_len);
    assign w_rd_off  = r_rev ? (r_len - c_LEN_W'(1) - r_rd_cnt) : r_rd_cnt;
    assign w_rd_idx  = r_bb + c_BRAM_AW'(w_rd_off);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (I_Boot)      w_state_nxt = c_ST_BOOT;
            c_ST_BOOT:  if (w_boot_exit) w_state_nxt = (r_len == '0) ? c_ST_DONE : c_ST_LOAD;
            c_ST_LOAD:  if (w_ld_last)   w_state_nxt = c_ST_STORE;
            c_ST_STORE: if (w_st_last)   w_state_nxt = c_ST_DONE;
            c_ST_DONE:  if (I_Boot)      w_state_nxt = c_ST_IDLE;
            default:                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Boot framing: discard preamble words 0..2, capture descriptor words 3..7
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_started  <= 1'b0;
            r_word_cnt <= '0;
            r_lb       <= '0;
            r_len      <= '0;
            r_sb       <= '0;
            r_bb       <= '0;
            r_rev      <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            r_started  <= 1'b0;
            r_word_cnt <= '0;
        end else if (w_tok_take) begin
            if (w_tok_a) begin
                r_started  <= 1'b1;
                r_word_cnt <= 3'd1;
            end else begin
                r_word_cnt <= r_word_cnt + 3'd1;
                case (r_word_cnt)
                    3'd3:    r_lb  <= WIDTH_EXADDR'(w_tok_d);
                    3'd4:    r_len <= w_len_clamped;
                    3'd5:    r_sb  <= WIDTH_EXADDR'(w_tok_d);
                    3'd6:    r_bb  <= c_BRAM_AW'(w_tok_d);
                    3'd7:    r_rev <= w_tok_d[0];
                    default: ;
                endcase
            end
        end
    end

    // Load issue (N back-to-back requests) and response counting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ld_req    <= 1'b0;
            r_ld_addr   <= '0;
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
        end else if (r_state == c_ST_LOAD) begin
            if (r_issue_cnt < r_len) begin
                r_ld_req    <= 1'b1;
                r_ld_addr   <= r_lb + WIDTH_EXADDR'(r_issue_cnt);
                r_issue_cnt <= r_issue_cnt + c_LEN_W'(1);
            end else begin
                r_ld_req  <= 1'b0;
                r_ld_addr <= '0;
            end
            if (w_ld_resp) begin
                r_resp_cnt <= r_resp_cnt + c_LEN_W'(1);
            end
        end else begin
            r_ld_req    <= 1'b0;
            r_ld_addr   <= '0;
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
        end
    end

    // Store sequencing: present one word per cycle, hold while stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_st_req  <= 1'b0;
            r_st_addr <= '0;
            r_rd_cnt  <= '0;
        end else if (r_state == c_ST_STORE) begin
            if (w_rd_en) begin
                r_st_req  <= 1'b1;
                r_st_addr <= r_sb + WIDTH_EXADDR'(r_rd_cnt);
                r_rd_cnt  <= r_rd_cnt + c_LEN_W'(1);
            end else if (w_st_adv) begin
                r_st_req  <= 1'b0;
                r_st_addr <= '0;
            end
        end else begin
            r_st_req  <= 1'b0;
            r_st_addr <= '0;
            r_rd_cnt  <= '0;
        end
    end

    // BRAM: write on load responses, registered read during store
    always_ff @(posedge clock) begin
        if (w_ld_resp) begin
            r_mem[w_wr_idx] <= w_tok_d;
        end
        if (w_rd_en) begin
            r_bram_q <= r_mem[w_rd_idx];
        end
    end

    assign O_Ld_Req  = r_ld_req;
    assign O_Ld_Addr = r_ld_addr;
    assign O_Ld_BTk  = '0;
    assign O_St_Req  = r_st_req;
    assign O_St_Addr = r_st_addr;
    // Read register is not reset, so data is gated by the request.
    assign O_St_FTk  = {r_st_req, 3'b000,
                        r_st_req ? w_st_index : {WIDTH_INDEX{1'b0}},
                        r_st_req ? r_bram_q   : {WIDTH_DATA{1'b0}}};

    assign w_unused = &{1'b0, I_Ld_FTk[c_FTK_C], I_Ld_FTk[c_FTK_R], I_St_BTk[2:0], w_tok_i};

endmodule
`default_nettype wire

// File: tb/tb_electron_nest.sv
`default_nettype none
// ============================================================================
//  Module   : tb_electron_nest
//  Brief    : Table-driven bench for electron_nest with a load memory model,
//             a store memory model and store backpressure injection.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_electron_nest;

    localparam int c_FW = 46;

    logic            clock  = 1'b0;
    logic            reset  = 1'b0;
    logic            I_Boot = 1'b0;
    logic            O_Ld_Req;
    logic [31:0]     O_Ld_Addr;
    logic [c_FW-1:0] I_Ld_FTk;
    logic [3:0]      O_Ld_BTk;
    logic            O_St_Req;
    logic [31:0]     O_St_Addr;
    logic [c_FW-1:0] O_St_FTk;
    logic [3:0]      I_St_BTk;

    electron_nest dut (
        .clock     (clock),
        .reset     (reset),
        .I_Boot    (I_Boot),
        .O_Ld_Req  (O_Ld_Req),
        .O_Ld_Addr (O_Ld_Addr),
        .I_Ld_FTk  (I_Ld_FTk),
        .O_Ld_BTk  (O_Ld_BTk),
        .O_St_Req  (O_St_Req),
        .O_St_Addr (O_St_Addr),
        .O_St_FTk  (O_St_FTk),
        .I_St_BTk  (I_St_BTk)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]       lb, n, sb, bb, ctl;
        int                stall_at, stall_len, exp_ld, exp_st;
        logic [3:0][31:0]  exp_w;
    } vec_t;

    vec_t vecs [9];

    int checks = 0;
    int errors = 0;

    logic            boot_active = 1'b0;
    logic [c_FW-1:0] boot_tok    = '0;
    logic [c_FW-1:0] mem_tok     = '0;
    logic            st_n        = 1'b0;
    logic            prev_req    = 1'b0;
    logic [31:0]     prev_addr   = '0;
    logic [31:0]     exp_ld_addr = '0;
    int              ld_cnt = 0, ld_bad = 0, st_cnt = 0, fmt_bad = 0;
    logic            ld_dropped = 1'b0;
    int              stall_at = -1, stall_left = 0;
    logic            hold_valid = 1'b0;
    logic [31:0]     held_addr, held_d;
    logic [31:0]     smem [256];

    assign I_Ld_FTk = boot_active ? boot_tok : mem_tok;
    assign I_St_BTk = {st_n, 3'b000};

    // Load memory contents: word at address a is C0DE00xx with xx = a[7:0]
    function automatic logic [31:0] lmem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {24'd0, a[7:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // External memory model: responds one cycle after each load request,
    // captures accepted store words, injects store stalls
    always @(negedge clock) begin
        if (!reset) begin
            prev_req = 1'b0;
            mem_tok  = '0;
            st_n     = 1'b0;
        end else begin
            mem_tok  = prev_req ? {1'b1, 3'b000, prev_addr[9:0], lmem_word(prev_addr)} : '0;
            prev_req = O_Ld_Req;
            prev_addr = O_Ld_Addr;
            if (O_Ld_Req) begin
                if (ld_dropped || (O_Ld_Addr !== exp_ld_addr)) ld_bad++;
                exp_ld_addr = exp_ld_addr + 32'd1;
                ld_cnt++;
            end else if (ld_cnt > 0) begin
                ld_dropped = 1'b1;
            end
            st_n = 1'b0;
            if (O_St_Req) begin
                if (hold_valid) begin
                    chk("st_hold_addr", O_St_Addr, held_addr);
                    chk("st_hold_data", O_St_FTk[31:0], held_d);
                end
                if ((st_cnt == stall_at) && (stall_left > 0)) begin
                    st_n       = 1'b1;
                    stall_left--;
                    hold_valid = 1'b1;
                    held_addr  = O_St_Addr;
                    held_d     = O_St_FTk[31:0];
                end else begin
                    hold_valid = 1'b0;
                    smem[O_St_Addr[7:0]] = O_St_FTk[31:0];
`ifdef EXTEND_MEM_EN
                    if (O_St_FTk[45:32] !== {4'b1000, O_St_Addr[9:0]}) fmt_bad++;
`else
                    if (O_St_FTk[45:32] !== 14'h2000) fmt_bad++;
`endif
                    st_cnt++;
                end
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] lb, n, sb, bb, ctl,
                                input int sat, slen, eld, est,
                                input logic [31:0] w0, w1, w2, w3);
        vec_t t;
        t.lb = lb; t.n = n; t.sb = sb; t.bb = bb; t.ctl = ctl;
        t.stall_at = sat; t.stall_len = slen; t.exp_ld = eld; t.exp_st = est;
        t.exp_w[0] = w0; t.exp_w[1] = w1; t.exp_w[2] = w2; t.exp_w[3] = w3;
        return t;
    endfunction

    task automatic setup_vec(input vec_t t);
        for (int k = 0; k < 256; k++) smem[k] = '0;
        ld_cnt = 0; ld_bad = 0; st_cnt = 0; fmt_bad = 0;
        ld_dropped = 1'b0;
        exp_ld_addr = t.lb;
        stall_at = t.stall_at;
        stall_left = t.stall_len;
        hold_valid = 1'b0;
    endtask

    task automatic send(input logic v, input logic a, input logic [31:0] d);
        boot_tok = {v, a, 2'b00, 10'd0, d};
        @(negedge clock);
    endtask

    task automatic do_boot(input vec_t t, input bit restart);
        @(negedge clock); I_Boot = 1'b1;
        @(negedge clock); I_Boot = 1'b1;
        @(negedge clock); I_Boot = 1'b0;
        boot_active = 1'b1;
        if (restart) begin
            send(1'b1, 1'b1, 32'h77);
            send(1'b1, 1'b0, 32'h1);
            send(1'b1, 1'b0, 32'h2);
            send(1'b1, 1'b0, 32'hBAD);
            send(1'b1, 1'b0, 32'h999);
        end
        send(1'b1, 1'b1, 32'h55);
        send(1'b1, 1'b0, 32'h66);
        send(1'b1, 1'b0, 32'h67);
        send(1'b1, 1'b0, t.lb);
        send(1'b1, 1'b0, t.n);
        send(1'b0, 1'b1, 32'hFFFF);
        send(1'b1, 1'b0, t.sb);
        send(1'b1, 1'b0, t.bb);
        send(1'b1, 1'b0, t.ctl);
        boot_active = 1'b0;
        boot_tok = '0;
    endtask

    task automatic finish_vec(input vec_t t, input string nm);
        int nclamp;
        logic [31:0] a;
        nclamp = (t.n > 32'd256) ? 256 : int'(t.n);
        repeat (2 * nclamp + t.stall_len + 40) @(negedge clock);
        chk({nm, "_ld_count"}, ld_cnt, t.exp_ld);
        chk({nm, "_ld_seq_bad"}, ld_bad, 0);
        chk({nm, "_st_count"}, st_cnt, t.exp_st);
        chk({nm, "_st_fmt_bad"}, fmt_bad, 0);
        chk({nm, "_idle_reqs"}, {O_Ld_Req, O_St_Req}, 0);
        for (int m = 0; m < 4; m++) begin
            a = t.sb + 32'(m);
            chk($sformatf("%s_word%0d", nm, m), smem[a[7:0]], t.exp_w[m]);
        end
    endtask

    task automatic run_vec(input vec_t t, input string nm, input bit restart);
        setup_vec(t);
        do_boot(t, restart);
        finish_vec(t, nm);
    endtask

    initial begin
        vecs[0] = mk(32'h10, 4, 32'h40, 0, 0, -1, 0, 4, 4,
                     32'hC0DE0010, 32'hC0DE0011, 32'hC0DE0012, 32'hC0DE0013);
        vecs[1] = mk(32'h10, 4, 32'h40, 0, 1, -1, 0, 4, 4,
                     32'hC0DE0013, 32'hC0DE0012, 32'hC0DE0011, 32'hC0DE0010);
        vecs[2] = mk(32'h10, 4, 32'h40, 0, 0, 1, 3, 4, 4,
                     32'hC0DE0010, 32'hC0DE0011, 32'hC0DE0012, 32'hC0DE0013);
        vecs[3] = mk(32'h10, 0, 32'h40, 0, 0, -1, 0, 0, 0,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[4] = mk(32'h10, 4, 32'h40, 0, 0, -1, 0, 4, 4,
                     32'hC0DE0010, 32'hC0DE0011, 32'hC0DE0012, 32'hC0DE0013);
        vecs[5] = mk(32'h10, 4, 32'h80, 32'hFE, 0, -1, 0, 4, 4,
                     32'hC0DE0010, 32'hC0DE0011, 32'hC0DE0012, 32'hC0DE0013);
        vecs[6] = mk(32'h10, 4, 32'h80, 32'hFE, 3, -1, 0, 4, 4,
                     32'hC0DE0013, 32'hC0DE0012, 32'hC0DE0011, 32'hC0DE0010);
        vecs[7] = mk(32'hFFFFFFFE, 4, 32'hFFFFFFFF, 5, 0, -1, 0, 4, 4,
                     32'hC0DE00FE, 32'hC0DE00FF, 32'hC0DE0000, 32'hC0DE0001);
        vecs[8] = mk(32'h0, 300, 32'h200, 0, 0, -1, 0, 256, 256,
                     32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003);

        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst0_ld_req",  O_Ld_Req,  0);
        chk("rst0_ld_addr", O_Ld_Addr, 0);
        chk("rst0_st_req",  O_St_Req,  0);
        chk("rst0_st_addr", O_St_Addr, 0);
        chk("rst0_st_ftk",  O_St_FTk,  0);
        chk("rst0_ld_btk",  O_Ld_BTk,  0);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        chk("no_ld_before_boot", ld_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i), 1'b0);
        end

        // Framing restart by an a=1 word in the middle of a boot frame
        run_vec(vecs[0], "restart", 1'b1);

        // Asynchronous reset while loading, then a fresh boot
        setup_vec(vecs[8]);
        do_boot(vecs[8], 1'b0);
        for (int k = 0; k < 200 && ld_cnt < 10; k++) @(negedge clock);
        chk("midrst_reached_load", (ld_cnt >= 10), 1);
        reset = 1'b0;
        #1;
        chk("midrst_ld_req",  O_Ld_Req,  0);
        chk("midrst_ld_addr", O_Ld_Addr, 0);
        chk("midrst_st_req",  O_St_Req,  0);
        chk("midrst_st_ftk",  O_St_FTk,  0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        run_vec(vecs[0], "after_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
